// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered ALU execute stage with iterative shift-add multiply
// NZCV flag logic is built only when ALU_FLAGS_EN is defined; otherwise out_flags is tied to zero.
module alu_exec_stage #(
   parameter int N   = 32,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in_op,
   input  logic [N-1:0]   in_a,
   input  logic [N-1:0]   in_b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_result,
   output logic [3:0]     out_flags,
   output logic           busy
);
   localparam int SW = $clog2(N);

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_AND = OPW'(2);
   localparam logic [OPW-1:0] OP_OR  = OPW'(3);
   localparam logic [OPW-1:0] OP_XOR = OPW'(4);
   localparam logic [OPW-1:0] OP_NOT = OPW'(5);
   localparam logic [OPW-1:0] OP_SLL = OPW'(6);
   localparam logic [OPW-1:0] OP_SRL = OPW'(7);
   localparam logic [OPW-1:0] OP_MUL = OPW'(8);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DONE
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  a_reg;
   logic [N-1:0]  b_reg;
   logic [N-1:0]  acc;
   logic [SW-1:0] cnt;
   logic [N-1:0]  alu_res;
   logic [SW-1:0] shamt;
   logic          slot_free;
   logic          accept;
   logic          is_mul;
   logic          load_single;
   logic          load_mul;
   logic          last_iter;

   // Shift amount is masked to log2(N) bits, so it can never reach N.
   assign shamt       = in_b[SW-1:0];
   assign slot_free   = !out_valid || out_ready;
   assign in_ready    = (state == IDLE) && slot_free;
   assign accept      = in_valid && in_ready;
   assign is_mul      = (in_op == OP_MUL);
   assign load_single = accept && !is_mul;
   assign load_mul    = (state == DONE) && slot_free;
   assign last_iter   = (cnt == SW'(N - 1));
   assign busy        = (state == MUL);

   always_comb begin
      alu_res = '0;
      case (in_op)
         OP_ADD:  alu_res = in_a + in_b;
         OP_SUB:  alu_res = in_a - in_b;
         OP_AND:  alu_res = in_a & in_b;
         OP_OR:   alu_res = in_a | in_b;
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_NOT:  alu_res = ~in_a;
         OP_SLL:  alu_res = in_a << shamt;
         OP_SRL:  alu_res = in_a >> shamt;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && is_mul) state_nxt = MUL;
         MUL:     if (last_iter) state_nxt = DONE;
         DONE:    if (slot_free) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // One multiplier bit per cycle: N iterations, cnt tracks the bit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else if (accept && is_mul) begin
         a_reg <= in_a;
         b_reg <= in_b;
         acc   <= '0;
         cnt   <= '0;
      end else if (state == MUL) begin
         if (b_reg[0]) begin
            acc <= acc + a_reg;
         end
         a_reg <= a_reg << 1;
         b_reg <= b_reg >> 1;
         cnt   <= cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
      end else if (load_single) begin
         out_valid  <= 1'b1;
         out_result <= alu_res;
      end else if (load_mul) begin
         out_valid  <= 1'b1;
         out_result <= acc;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

`ifdef ALU_FLAGS_EN
   logic [3:0] flags_c;
   logic [3:0] flags_r;
   logic       c_bit;
   logic       v_bit;

   // Carry out of an add shows up as a wrapped sum smaller than an operand.
   always_comb begin
      c_bit = 1'b0;
      v_bit = 1'b0;
      case (in_op)
         OP_ADD: begin
            c_bit = (alu_res < in_a);
            v_bit = (in_a[N-1] == in_b[N-1]) && (alu_res[N-1] != in_a[N-1]);
         end
         OP_SUB: begin
            c_bit = (in_a >= in_b);
            v_bit = (in_a[N-1] != in_b[N-1]) && (alu_res[N-1] != in_a[N-1]);
         end
         default: begin
            c_bit = 1'b0;
            v_bit = 1'b0;
         end
      endcase
      flags_c = (in_op <= OP_MUL) ? {alu_res[N-1], (alu_res == '0), c_bit, v_bit} : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= 4'b0000;
      end else if (load_single) begin
         flags_r <= flags_c;
      end else if (load_mul) begin
         flags_r <= {acc[N-1], (acc == '0), 2'b00};
      end
   end

   assign out_flags = flags_r;
`else
   assign out_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized and directed bench for alu_exec_stage
// Scoreboard model tracks accepted ops and the cycle each result must appear.
module tb_alu_exec_stage;
   localparam int N   = 32;
   localparam int OPW = 4;
   localparam longint SMAX = 2147483647;
   localparam longint SMIN = -SMAX - 1;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] in_op;
   logic [N-1:0]   in_a;
   logic [N-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_result;
   logic [3:0]     out_flags;
   logic           busy;

   int     checks   = 0;
   int     failures = 0;
   longint cyc      = 0;

   logic [N-1:0] q_res[$];
   logic [3:0]   q_flg[$];
   longint       q_acc[$];
   longint       q_rdy[$];
   bit           q_mul[$];

   alu_exec_stage #(.N(N), .OPW(OPW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] ef(input logic [3:0] f);
`ifdef ALU_FLAGS_EN
      return f;
`else
      return 4'b0000 & f;
`endif
   endfunction

   // Reference: plain arithmetic on the operands, flags from signed/unsigned ranges.
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [63:0] wide;
      longint      s;
      logic        c;
      logic        v;
      logic [3:0]  f;
      r = 0;
      c = 0;
      v = 0;
      case (op)
         4'd0: begin
            wide = 64'(a) + 64'(b);
            r    = wide[31:0];
            c    = wide[32];
            s    = longint'($signed(a)) + longint'($signed(b));
            v    = (s > SMAX) || (s < SMIN);
         end
         4'd1: begin
            r = a - b;
            c = (a >= b);
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > SMAX) || (s < SMIN);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: r = a << (b % 32);
         4'd7: r = a >> (b % 32);
         4'd8: begin
            wide = 64'(a) * 64'(b);
            r    = wide[31:0];
         end
         default: r = 0;
      endcase
      f = (op <= 4'd8) ? {r[31], (r == 0), c, v} : 4'b0000;
      return {r, ef(f)};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin : mon
      logic        exp_ov;
      logic        exp_busy;
      logic        exp_ir;
      logic        mul_open;
      logic [35:0] m;
      if (!rst_n) begin
         q_res.delete();
         q_flg.delete();
         q_acc.delete();
         q_rdy.delete();
         q_mul.delete();
      end else begin
         exp_ov   = (q_res.size() > 0) && (cyc >= q_rdy[0]);
         mul_open = (q_res.size() > 0) && q_mul[0] && (cyc < q_rdy[0]);
         exp_busy = mul_open && (cyc < q_acc[0] + N);
         exp_ir   = !mul_open && (!exp_ov || out_ready);
         chk("out_valid", 64'(out_valid), 64'(exp_ov));
         chk("busy", 64'(busy), 64'(exp_busy));
         chk("in_ready", 64'(in_ready), 64'(exp_ir));
         if (exp_ov) begin
            chk("result", 64'(out_result), 64'(q_res[0]));
            chk("flags", 64'(out_flags), 64'(q_flg[0]));
         end
         if (exp_ov && out_ready) begin
            void'(q_res.pop_front());
            void'(q_flg.pop_front());
            void'(q_acc.pop_front());
            void'(q_rdy.pop_front());
            void'(q_mul.pop_front());
         end
         if (in_valid && exp_ir) begin
            m = model(in_op, in_a, in_b);
            q_res.push_back(m[35:4]);
            q_flg.push_back(m[3:0]);
            q_acc.push_back(cyc + 1);
            q_rdy.push_back((in_op == 4'd8) ? cyc + 1 + N + 1 : cyc + 1);
            q_mul.push_back(in_op == 4'd8);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit ok;
      ok       = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      chk("send_accept", 64'(ok), 64'(1));
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      int          nb;
      int          nr;
      int          nv;
      logic [31:0] xa;
      logic [31:0] xb;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_result", 64'(out_result), 64'(0));
      chk("rst_out_flags", 64'(out_flags), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      rst_n = 1'b1;
      step();

      send(4'd5, 32'h0000_FFFF, $urandom);
      @(negedge clk);
      chk("not_res", 64'(out_result), 64'(32'hFFFF_0000));
      chk("not_flags", 64'(out_flags), 64'(ef(4'b1000)));
      step();
      send(4'd0, 32'h7FFF_FFFF, 32'h1);
      @(negedge clk);
      chk("add_res", 64'(out_result), 64'(32'h8000_0000));
      chk("add_flags", 64'(out_flags), 64'(ef(4'b1001)));
      step();
      send(4'd1, 32'd5, 32'd5);
      @(negedge clk);
      chk("sub_res", 64'(out_result), 64'(0));
      chk("sub_flags", 64'(out_flags), 64'(ef(4'b0110)));
      step();
      send(4'd12, 32'd5, 32'd5);
      @(negedge clk);
      chk("undef_res", 64'(out_result), 64'(0));
      chk("undef_flags", 64'(out_flags), 64'(0));
      step();
      send(4'd6, 32'hDEAD_BEEF, 32'h20);
      @(negedge clk);
      chk("sll_zero_amt", 64'(out_result), 64'(32'hDEAD_BEEF));
      step();
      send(4'd7, 32'h8000_0000, 32'h3F);
      @(negedge clk);
      chk("srl_masked", 64'(out_result), 64'(32'h1));
      step();

      // MUL latency and busy window
      send(4'd8, 32'd7, 32'd6);
      lat = 999;
      nb  = 0;
      nr  = 0;
      for (int i = 0; i < N + 6; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
         if (busy) nb++;
         if (!in_ready) nr++;
      end
      chk("mul_latency", 64'(lat), 64'(N + 1));
      chk("mul_busy_cycles", 64'(nb), 64'(N));
      chk("mul_stall_cycles", 64'(nr), 64'(N + 1));
      chk("mul_res", 64'(out_result), 64'(42));
      chk("mul_flags", 64'(out_flags), 64'(0));
      step();

      // Backpressure: result held, next op waits, then goes in the release cycle
      out_ready = 1'b0;
      send(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
      in_valid = 1'b1;
      in_op    = 4'd0;
      in_a     = 32'd3;
      in_b     = 32'd4;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'(0));
         chk("bp_hold", 64'(out_result), 64'(32'h0FF0_0FF0));
      end
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_next_res", 64'(out_result), 64'(7));
      step();

      // Back-to-back XOR then SLL
      xa       = $urandom;
      xb       = $urandom;
      in_valid = 1'b1;
      in_op    = 4'd4;
      in_a     = xa;
      in_b     = xb;
      @(negedge clk);
      chk("b2b_ready1", 64'(in_ready), 64'(1));
      step();
      in_op = 4'd6;
      in_a  = 32'd1;
      in_b  = 32'd31;
      @(negedge clk);
      chk("b2b_res1", 64'(out_result), 64'(xa ^ xb));
      chk("b2b_ready2", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_valid2", 64'(out_valid), 64'(1));
      chk("b2b_res2", 64'(out_result), 64'(32'h8000_0000));
      step();

      // Async reset while a result is held
      out_ready = 1'b0;
      send(4'd2, 32'h0000_FFFF, 32'h00FF_00FF);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_hold_valid", 64'(out_valid), 64'(0));
      chk("rst_hold_result", 64'(out_result), 64'(0));
      @(negedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();

      // Async reset in the middle of a MUL
      send(4'd0, 32'd1, 32'd1);
      step();
      send(4'd8, $urandom, $urandom);
      repeat (5) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_mul_busy", 64'(busy), 64'(0));
      chk("rst_mul_result", 64'(out_result), 64'(0));
      chk("rst_mul_flags", 64'(out_flags), 64'(0));
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      nv    = 0;
      for (int i = 0; i < N + 6; i++) begin
         @(negedge clk);
         if (out_valid) nv++;
      end
      chk("mul_aborted", 64'(nv), 64'(0));

      // Randomized stream with random backpressure
      for (int i = 0; i < 3000; i++) begin
         step();
         out_ready = ($urandom % 4) != 0;
         in_valid  = ($urandom % 3) != 0;
         in_op     = 4'($urandom);
         in_a      = pick();
         in_b      = (($urandom % 5) == 0) ? in_a : pick();
      end
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (N + 6) @(negedge clk);
      chk("drain_empty", 64'(q_res.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
